axis_tlast_packer: RTL and testbench
====================================

Name: axis_tlast_packer

Overview:
- Sits directly downstream of the custom AXIS FIFO, between its master port and the Xilinx DMA S2MM slave.
- Packs narrow model-output beats into DMA-width words.
- Generates a deterministic TLAST every FRAME_LEN input beats, so DMA transfer length matches the model output size rather than FIFO-empty timing.
- Partial final words are flagged with TKEEP.

Parameters:
- IN_WIDTH, 8, input beat width in bits; multiple of 8.
- OUT_WIDTH, 32, output word width in bits; integer multiple of IN_WIDTH. RATIO = OUT_WIDTH/IN_WIDTH >= 1.
- FRAME_LEN, 16, input beats per frame (>= 1); TLAST is emitted on the word containing the last beat.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- s_axis_tvalid  input  1  beat valid from FIFO.
- s_axis_tdata  input  IN_WIDTH  beat data.
- s_axis_tlast  input  1  upstream TLAST; used only with the optional feature.
- s_axis_tready  output  1  packer can accept beat.
- m_axis_tvalid  output  1  packed word valid to DMA.
- m_axis_tdata  output  OUT_WIDTH  packed word.
- m_axis_tkeep  output  OUT_WIDTH/8  byte enables.
- m_axis_tlast  output  1  end of frame.
- m_axis_tready  input  1  DMA accepts word.

Behaviour:
- Reset (async assert, sync deassert on clk):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0.
  - Lane counter=0, frame counter=0, accumulator=0.
- Lane packing and word close:
  - Little-endian: the beat with lane index i occupies bits [(i+1)*IN_WIDTH-1 : i*IN_WIDTH].
  - Accepted beat (s_axis_tvalid && s_axis_tready) is written into lane i of the accumulator; lane counter increments.
  - A beat "closes" the word if lane counter==RATIO-1 OR frame counter==FRAME_LEN-1 (or the optional input-TLAST condition holds).
- On a closing beat, at the same edge:
  - Accumulator contents (including the current beat) are loaded into the output register; m_axis_tvalid<=1.
  - m_axis_tkeep<= ones for the filled lanes only (lanes 0..i, each lane IN_WIDTH/8 bits); unused lanes have tdata=0.
  - m_axis_tlast<=1 iff closed by the frame-end condition.
  - Lane counter<=0 and accumulator<=0. Frame counter<=0 if frame end, else +1.
- Non-closing beat: frame counter+1, lane counter+1, output register unchanged.
- Handshake:
  - s_axis_tready = ~m_axis_tvalid | m_axis_tready. Depends only on registered state and m_axis_tready, never on s_axis_tvalid/tdata/tlast.
  - m_axis_tvalid drops to 0 after a handshake unless a closing beat loads a new word at the same edge; back-to-back words give full throughput.
  - Output fields hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Latency: a closing beat accepted at edge k yields m_axis_tvalid=1 immediately after edge k.
- Throughput: 1 input beat/cycle sustained when m_axis_tready=1.
- Boundaries:
  - RATIO=1: every beat closes; tkeep all ones.
  - FRAME_LEN not a multiple of RATIO: the last word of each frame is partial; the next frame starts at lane 0.
  - FRAME_LEN=1: every beat carries TLAST.
  - Frame counter wraps only via the frame-end reset, never by overflow; width $clog2(FRAME_LEN+1).
  - Reset mid-frame discards the partial word and any held output word; the first beat after reset is lane 0 of frame beat 0.

Optional Feature:
- Macro: AXIS_PACKER_IN_TLAST_EN.
- Defined: an accepted beat with s_axis_tlast=1 is treated as frame end. It closes the word with m_axis_tlast=1 and partial tkeep, and resets the frame counter, regardless of the count.
- Undefined: s_axis_tlast is ignored; frames are delimited solely by FRAME_LEN.

Test Plan:
- Defaults, m_axis_tready=1, 16 beats 0x00..0x0F → 4 words:
  - 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C.
  - tkeep=0xF on all; tlast only on the 4th word.
- FRAME_LEN=6, RATIO=4, beats 0x10..0x15 → words 0x13121110 (tkeep 0xF, tlast 0), then 0x00001514 (tkeep 0x3, tlast 1). Next frame restarts at lane 0.
- Backpressure: m_axis_tready=0 for 5 cycles while a word is held:
  - tdata/tkeep/tlast stable, s_axis_tready=0.
  - No beats lost; on release, one word per cycle.
- Reset asserted after 2 of 4 lanes filled:
  - Outputs go to 0 asynchronously.
  - After release, 4 beats 0xA0..0xA3 → single word 0xA3A2A1A0 with no residue.
- With AXIS_PACKER_IN_TLAST_EN, s_axis_tlast on the 3rd beat (0x30,0x31,0x32) → word 0x00323130, tkeep 0x7, tlast 1. The frame counter restarts, so the next 16 beats give tlast on their 4th word.
- Random valid/ready toggling over 1000 beats → output stream byte-identical to input; tlast count = 1000/FRAME_LEN, floored.

Source files
------------

// File: rtl/axis_tlast_packer.sv
// Packs IN_WIDTH AXIS beats into OUT_WIDTH words with a TLAST every FRAME_LEN beats.
// Optional AXIS_PACKER_IN_TLAST_EN: an accepted upstream TLAST also ends the frame.
module axis_tlast_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int FRAME_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]    s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready
);

  localparam int RATIO      = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int FRAME_W    = $clog2(FRAME_LEN + 1);
  localparam int KEEP_W     = OUT_WIDTH / 8;
  localparam int LANE_BYTES = IN_WIDTH / 8;

  // Byte enables for lanes 0..last_lane.
  function automatic logic [KEEP_W-1:0] keep_mask(input logic [LANE_W-1:0] last_lane);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int l = 0; l < RATIO; l++) begin
      m[l*LANE_BYTES +: LANE_BYTES] = (LANE_W'(l) <= last_lane) ? {LANE_BYTES{1'b1}}
                                                                 : {LANE_BYTES{1'b0}};
    end
    return m;
  endfunction

  logic [LANE_W-1:0]    lane_cnt_r;
  logic [FRAME_W-1:0]   frame_cnt_r;
  logic [OUT_WIDTH-1:0] acc_r;
  logic                 m_tvalid_r;
  logic [OUT_WIDTH-1:0] m_tdata_r;
  logic [KEEP_W-1:0]    m_tkeep_r;
  logic                 m_tlast_r;

  logic                 ready_s;
  logic                 accept_s;
  logic                 frame_end_s;
  logic                 word_end_s;
  logic                 close_s;
  logic [OUT_WIDTH-1:0] merged_s;

  assign ready_s  = ~m_tvalid_r | m_axis_tready;
  assign accept_s = s_axis_tvalid & ready_s;

  // Word / frame close conditions for the beat currently presented.
  always_comb begin
    word_end_s = (lane_cnt_r == LANE_W'(RATIO - 1));
`ifdef AXIS_PACKER_IN_TLAST_EN
    frame_end_s = (frame_cnt_r == FRAME_W'(FRAME_LEN - 1)) | s_axis_tlast;
`else
    frame_end_s = (frame_cnt_r == FRAME_W'(FRAME_LEN - 1));
`endif
    close_s = word_end_s | frame_end_s;
  end

`ifndef AXIS_PACKER_IN_TLAST_EN
  logic unused_tlast_s;
  assign unused_tlast_s = s_axis_tlast;
`endif

  // Accumulator with the incoming beat dropped into the current lane.
  always_comb begin
    merged_s = acc_r;
    for (int l = 0; l < RATIO; l++) begin
      merged_s[l*IN_WIDTH +: IN_WIDTH] = (LANE_W'(l) == lane_cnt_r) ? s_axis_tdata
                                                                    : acc_r[l*IN_WIDTH +: IN_WIDTH];
    end
  end

  // Packing state and the registered output word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_r  <= '0;
      frame_cnt_r <= '0;
      acc_r       <= '0;
      m_tvalid_r  <= 1'b0;
      m_tdata_r   <= '0;
      m_tkeep_r   <= '0;
      m_tlast_r   <= 1'b0;
    end else begin
      if (accept_s && close_s) begin
        m_tvalid_r  <= 1'b1;
        m_tdata_r   <= merged_s;
        m_tkeep_r   <= keep_mask(lane_cnt_r);
        m_tlast_r   <= frame_end_s;
        lane_cnt_r  <= '0;
        acc_r       <= '0;
        frame_cnt_r <= frame_end_s ? '0 : frame_cnt_r + FRAME_W'(1);
      end else begin
        if (m_axis_tready) begin
          m_tvalid_r <= 1'b0;
        end
        if (accept_s) begin
          acc_r       <= merged_s;
          lane_cnt_r  <= lane_cnt_r + LANE_W'(1);
          frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        end
      end
    end
  end

  assign s_axis_tready = ready_s;
  assign m_axis_tvalid = m_tvalid_r;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tkeep  = m_tkeep_r;
  assign m_axis_tlast  = m_tlast_r;

endmodule

// File: tb/tb_axis_tlast_packer.sv
// Directed bench for axis_tlast_packer: default instance (FRAME_LEN=16) and a FRAME_LEN=6 instance.
module tb_axis_tlast_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic [7:0]  s_tdata;
  logic        s_tlast;
  logic        m_tready;

  logic        a_sr, a_mv, a_ml;
  logic [31:0] a_md;
  logic [3:0]  a_mk;
  logic        b_sr, b_mv, b_ml;
  logic [31:0] b_md;
  logic [3:0]  b_mk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  word_t qa[$];
  word_t qb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  axis_tlast_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .FRAME_LEN(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tready(a_sr),
    .m_axis_tvalid(a_mv), .m_axis_tdata(a_md), .m_axis_tkeep(a_mk), .m_axis_tlast(a_ml),
    .m_axis_tready(m_tready)
  );

  axis_tlast_packer #(.IN_WIDTH(8), .OUT_WIDTH(32), .FRAME_LEN(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tready(b_sr),
    .m_axis_tvalid(b_mv), .m_axis_tdata(b_md), .m_axis_tkeep(b_mk), .m_axis_tlast(b_ml),
    .m_axis_tready(m_tready)
  );

  // Record every completed output handshake of both instances.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_mv && m_tready) qa.push_back('{a_md, a_mk, a_ml});
      if (b_mv && m_tready) qb.push_back('{b_md, b_mk, b_ml});
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    qa.delete(); qb.delete();
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int   n;
    logic got;
    n = 0; got = 1'b0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    while (!got && n < 200) begin
      @(negedge clk);
      if (a_sr) got = 1'b1;
      else n++;
      @(posedge clk); #1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL send_beat timeout data=%h", d);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int n);
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; m_tready = 1'b0;
    #3;
    total++; if (a_mv !== 1'b0)     begin bad++; $display("FAIL reset_tvalid got=%b exp=0", a_mv); end
    total++; if (a_md !== 32'h0)    begin bad++; $display("FAIL reset_tdata got=%h exp=0", a_md); end
    total++; if (a_mk !== 4'h0)     begin bad++; $display("FAIL reset_tkeep got=%h exp=0", a_mk); end
    total++; if (a_ml !== 1'b0)     begin bad++; $display("FAIL reset_tlast got=%b exp=0", a_ml); end
    total++; if (a_sr !== 1'b1)     begin bad++; $display("FAIL reset_tready got=%b exp=1", a_sr); end
    apply_reset();
  endtask

  task automatic test_pack();
    logic [31:0] ed[4];
    logic        el[4];
    ed = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    el = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int i = 0; i < 16; i++) send_beat(8'(i), 1'b0);
    drain(3);
    total++; if (qa.size() !== 4) begin bad++; $display("FAIL pack_count got=%0d exp=4", qa.size()); end
    for (int i = 0; i < 4 && i < qa.size(); i++) begin
      total++; if (qa[i].d !== ed[i]) begin bad++; $display("FAIL pack_data[%0d] got=%h exp=%h", i, qa[i].d, ed[i]); end
      total++; if (qa[i].k !== 4'hF)  begin bad++; $display("FAIL pack_keep[%0d] got=%h exp=f", i, qa[i].k); end
      total++; if (qa[i].l !== el[i]) begin bad++; $display("FAIL pack_last[%0d] got=%b exp=%b", i, qa[i].l, el[i]); end
    end
  endtask

  task automatic test_partial();
    logic [31:0] ed[3];
    logic [3:0]  ek[3];
    logic        el[3];
    ed = '{32'h13121110, 32'h00001514, 32'h23222120};
    ek = '{4'hF, 4'h3, 4'hF};
    el = '{1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 6; i++) send_beat(8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) send_beat(8'h20 + 8'(i), 1'b0);
    drain(3);
    total++; if (qb.size() !== 3) begin bad++; $display("FAIL partial_count got=%0d exp=3", qb.size()); end
    for (int i = 0; i < 3 && i < qb.size(); i++) begin
      total++; if (qb[i].d !== ed[i]) begin bad++; $display("FAIL partial_data[%0d] got=%h exp=%h", i, qb[i].d, ed[i]); end
      total++; if (qb[i].k !== ek[i]) begin bad++; $display("FAIL partial_keep[%0d] got=%h exp=%h", i, qb[i].k, ek[i]); end
      total++; if (qb[i].l !== el[i]) begin bad++; $display("FAIL partial_last[%0d] got=%b exp=%b", i, qb[i].l, el[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed[3];
    int          c0;
    ed = '{32'h43424140, 32'h47464544, 32'h4B4A4948};
    apply_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(8'h40 + 8'(i), 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'h44;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (a_mv !== 1'b1)          begin bad++; $display("FAIL bp_valid c%0d got=%b exp=1", c, a_mv); end
      total++; if (a_md !== 32'h43424140)  begin bad++; $display("FAIL bp_data c%0d got=%h exp=43424140", c, a_md); end
      total++; if (a_mk !== 4'hF)          begin bad++; $display("FAIL bp_keep c%0d got=%h exp=f", c, a_mk); end
      total++; if (a_sr !== 1'b0)          begin bad++; $display("FAIL bp_sready c%0d got=%b exp=0", c, a_sr); end
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    c0 = cyc;
    for (int i = 4; i < 12; i++) send_beat(8'h40 + 8'(i), 1'b0);
    total++; if (cyc - c0 !== 8) begin bad++; $display("FAIL bp_throughput got=%0d cycles exp=8", cyc - c0); end
    drain(3);
    total++; if (qa.size() !== 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", qa.size()); end
    for (int i = 0; i < 3 && i < qa.size(); i++) begin
      total++; if (qa[i].d !== ed[i]) begin bad++; $display("FAIL bp_word[%0d] got=%h exp=%h", i, qa[i].d, ed[i]); end
      total++; if (qa[i].l !== 1'b0)  begin bad++; $display("FAIL bp_last[%0d] got=%b exp=0", i, qa[i].l); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) send_beat(8'hD0 + 8'(i), 1'b0);
    send_beat(8'hE0, 1'b0);
    send_beat(8'hE1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (a_md !== 32'h0) begin bad++; $display("FAIL rstmid_tdata got=%h exp=0", a_md); end
    total++; if (a_mk !== 4'h0)  begin bad++; $display("FAIL rstmid_tkeep got=%h exp=0", a_mk); end
    total++; if (a_mv !== 1'b0)  begin bad++; $display("FAIL rstmid_tvalid got=%b exp=0", a_mv); end
    total++; if (a_ml !== 1'b0)  begin bad++; $display("FAIL rstmid_tlast got=%b exp=0", a_ml); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) send_beat(8'hA0 + 8'(i), 1'b0);
    drain(3);
    total++; if (qa.size() !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", qa.size()); end
    if (qa.size() > 0) begin
      total++; if (qa[0].d !== 32'hA3A2A1A0) begin bad++; $display("FAIL rstmid_data got=%h exp=a3a2a1a0", qa[0].d); end
      total++; if (qa[0].k !== 4'hF)         begin bad++; $display("FAIL rstmid_keep got=%h exp=f", qa[0].k); end
      total++; if (qa[0].l !== 1'b0)         begin bad++; $display("FAIL rstmid_last got=%b exp=0", qa[0].l); end
    end
  endtask

`ifdef AXIS_PACKER_IN_TLAST_EN
  task automatic test_in_tlast();
    logic [31:0] ed[5];
    logic [3:0]  ek[5];
    logic        el[5];
    ed = '{32'h00323130, 32'h43424140, 32'h47464544, 32'h4B4A4948, 32'h4F4E4D4C};
    ek = '{4'h7, 4'hF, 4'hF, 4'hF, 4'hF};
    el = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    send_beat(8'h30, 1'b0);
    send_beat(8'h31, 1'b0);
    send_beat(8'h32, 1'b1);
    for (int i = 0; i < 16; i++) send_beat(8'h40 + 8'(i), 1'b0);
    drain(3);
    total++; if (qa.size() !== 5) begin bad++; $display("FAIL intlast_count got=%0d exp=5", qa.size()); end
    for (int i = 0; i < 5 && i < qa.size(); i++) begin
      total++; if (qa[i].d !== ed[i]) begin bad++; $display("FAIL intlast_data[%0d] got=%h exp=%h", i, qa[i].d, ed[i]); end
      total++; if (qa[i].k !== ek[i]) begin bad++; $display("FAIL intlast_keep[%0d] got=%h exp=%h", i, qa[i].k, ek[i]); end
      total++; if (qa[i].l !== el[i]) begin bad++; $display("FAIL intlast_last[%0d] got=%b exp=%b", i, qa[i].l, el[i]); end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] bytes[$];
    int         nlast;
    int         nerr;
    bit         done;
    apply_reset();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
          end
          send_beat(8'(i), 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (!done) m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain(5);
    nlast = 0; nerr = 0;
    foreach (qa[w]) begin
      if (qa[w].l) nlast++;
      for (int j = 0; j < 4; j++) begin
        if (qa[w].k[j]) bytes.push_back(qa[w].d[8*j +: 8]);
      end
    end
    total++; if (bytes.size() !== 1000) begin bad++; $display("FAIL rand_bytes got=%0d exp=1000", bytes.size()); end
    foreach (bytes[i]) if (bytes[i] !== 8'(i)) nerr++;
    total++; if (nerr !== 0)  begin bad++; $display("FAIL rand_data got=%0d wrong bytes exp=0", nerr); end
    total++; if (nlast !== 62) begin bad++; $display("FAIL rand_tlast got=%0d exp=62", nlast); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_partial();
    test_backpressure();
    test_reset_mid();
`ifdef AXIS_PACKER_IN_TLAST_EN
    test_in_tlast();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
